// File: rtl/fg_burst_waveform_gen_if.sv
// fg_burst_waveform_gen_if: shadow-configuration handshake bundle for the burst waveform generator
interface fg_burst_waveform_gen_if #(
  parameter int COUNTER_BITWIDTH = 32,
  parameter int WAVEFORM_BITWIDTH = 16,
  parameter int BURST_BITWIDTH = 8
);
  logic cfg_valid_i;
  logic cfg_ready_o;
  logic [COUNTER_BITWIDTH-1:0] period_i;
  logic [COUNTER_BITWIDTH-1:0] on_time_i;
  logic [WAVEFORM_BITWIDTH-1:0] k_rise_i;
  logic [WAVEFORM_BITWIDTH-1:0] k_fall_i;
  logic [WAVEFORM_BITWIDTH-1:0] amplitude_i;
  logic [1:0] mode_i;
  logic [BURST_BITWIDTH-1:0] burst_count_i;
  logic invert_i;
  modport master (
    output cfg_valid_i, period_i, on_time_i, k_rise_i, k_fall_i, amplitude_i, mode_i, burst_count_i, invert_i,
    input cfg_ready_o
  );
  modport slave (
    input cfg_valid_i, period_i, on_time_i, k_rise_i, k_fall_i, amplitude_i, mode_i, burst_count_i, invert_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/fg_burst_waveform_gen.sv
// fg_burst_waveform_gen: self-timed trapezoid/pulse generator with shadow config and burst modes
module fg_burst_waveform_gen #(
  parameter int COUNTER_BITWIDTH = 32,
  parameter int WAVEFORM_BITWIDTH = 16,
  parameter int BURST_BITWIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_en_i,
  input  logic enable_i,
  fg_burst_waveform_gen_if.slave cfg,
  output logic signed [WAVEFORM_BITWIDTH:0] out_o,
  output logic period_start_o,
  output logic busy_o,
  output logic done_o
);
  localparam int CB = COUNTER_BITWIDTH;
  localparam int WB = WAVEFORM_BITWIDTH;
  localparam int BB = BURST_BITWIDTH;
  typedef struct packed {
    logic [CB-1:0] period;
    logic [CB-1:0] on_time;
    logic [WB-1:0] k_rise;
    logic [WB-1:0] k_fall;
    logic [WB-1:0] amp;
    logic [1:0] mode;
    logic [BB-1:0] burst;
    logic inv;
  } cfg_t;
  typedef enum logic [2:0] {IDLE, RISE, ON, FALL, LOW} state_t;
  state_t state_q, state_d;
  cfg_t act_q, act_d, pend_q, pend_d, cfg_in;
  logic [CB-1:0] cnt_q, cnt_d;
  logic [WB-1:0] val_q, val_d, step;
  logic [BB-1:0] bcnt_q, bcnt_d, target;
  logic ready_q, ready_d, pstart_q, pstart_d, done_q, done_d;
  logic signed [WB:0] out_q, out_d;
  logic signed [WB+1:0] sum, amp_s;
  logic run, wrap, xfer, apply, start, stop, finish;
  assign cfg_in = '{period: cfg.period_i, on_time: cfg.on_time_i, k_rise: cfg.k_rise_i, k_fall: cfg.k_fall_i,
                    amp: cfg.amplitude_i, mode: cfg.mode_i, burst: cfg.burst_count_i, inv: cfg.invert_i};
  assign run = state_q != IDLE;
  assign wrap = run && cnt_q == act_q.period - 1'b1;
  assign xfer = cfg.cfg_valid_i && ready_q;
  assign apply = clk_en_i && (!run || wrap);
  assign start = enable_i && pend_q.period > CB'(1);
  assign stop = !enable_i || act_q.period < CB'(2);
  assign target = act_q.mode == 2'd2 || act_q.burst == '0 ? BB'(1) : act_q.burst;
  assign finish = wrap && (act_q.mode == 2'd1 || act_q.mode == 2'd2) && bcnt_q + 1'b1 >= target;
  // One shared adder with a headroom bit so a large slope never wraps before clamping
  assign sum = $signed({2'b00, val_q}) + (state_q == RISE ? $signed({2'b00, act_q.k_rise}) : -$signed({2'b00, act_q.k_fall}));
  assign amp_s = $signed({2'b00, act_q.amp});
  assign step = sum < 0 ? '0 : state_q == RISE && sum > amp_s ? act_q.amp : sum[WB-1:0];
  assign cfg.cfg_ready_o = ready_q;
  assign out_o = out_q;
  assign period_start_o = pstart_q;
  assign busy_o = run;
  assign done_o = done_q;
  // Shadow config: accept into pending on handshake, promote to active in IDLE or at a wrap
  always_comb begin
    pend_d = xfer ? cfg_in : pend_q;
    act_d = apply ? pend_q : act_q;
    ready_d = xfer ? 1'b0 : apply ? 1'b1 : ready_q;
    out_d = act_q.inv ? -$signed({1'b0, val_q}) : $signed({1'b0, val_q});
  end
  // Waveform FSM: stop/done beats the wrap, the wrap beats the on-time match
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    val_d = val_q;
    bcnt_d = bcnt_q;
    pstart_d = 1'b0;
    done_d = 1'b0;
    if (clk_en_i && !run) begin
      state_d = start ? RISE : IDLE;
      cnt_d = '0;
      val_d = '0;
      bcnt_d = '0;
      pstart_d = start;
    end else if (clk_en_i && (stop || finish)) begin
      state_d = IDLE;
      cnt_d = '0;
      val_d = '0;
      done_d = !stop;
    end else if (clk_en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      val_d = state_q == ON ? act_q.amp : state_q == LOW ? '0 : step;
      state_d = wrap ? RISE
              : (state_q == RISE || state_q == ON) && cnt_d == act_q.on_time ? FALL
              : state_q == RISE && val_d == act_q.amp ? ON
              : state_q == FALL && val_d == '0 ? LOW
              : state_q;
      bcnt_d = wrap ? bcnt_q + 1'b1 : bcnt_q;
      pstart_d = wrap;
    end
  end
  // State registers; reset clears both config slots so nothing runs until a config is loaded
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      val_q <= '0;
      bcnt_q <= '0;
      act_q <= '0;
      pend_q <= '0;
      ready_q <= 1'b1;
      pstart_q <= 1'b0;
      done_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      bcnt_q <= bcnt_d;
      act_q <= act_d;
      pend_q <= pend_d;
      ready_q <= ready_d;
      pstart_q <= pstart_d;
      done_q <= done_d;
      out_q <= out_d;
    end
  end
endmodule
